// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the request, ALU-drive and response signals of alu_cmd_sequencer.
//   cmd_*  : operation request (valid/ready) from the issue logic
//   alu_*  : registered operands/control to the external ALU, result back
//   rsp_*  : captured result with its tag (valid/ready) to the consumer
// Modports:
//   master : issue logic / consumer / ALU side
//   slave  : the sequencer itself
interface alu_cmd_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [3:0]       cmd_ctrl;
    logic [TAG_W-1:0] cmd_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_ctrl, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_y,
        input  rsp_valid, rsp_data, rsp_zero, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_ctrl, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_y,
        output rsp_valid, rsp_data, rsp_zero, rsp_tag,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the 32-bit combinational ALU.
// Requests are buffered in a DEPTH-entry FIFO, issued one at a time as
// registered alu_a/alu_b/alu_ctrl, held for ALU_LAT cycles, then alu_y is
// captured and returned with the request tag. Responses stay in order.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : alu_cmd_sequencer_if.slave (cmd_*, alu_*, rsp_*)
//   busy        : FSM not idle or FIFO non-empty
//   fifo_count  : current FIFO occupancy
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    alu_cmd_sequencer_if.slave           bus,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int LAT_W = $clog2(ALU_LAT+1);
    localparam int ENT_W = 32 + 32 + 4 + TAG_W;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [LAT_W-1:0] lat_q, lat_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [31:0]      head_a;
    logic [31:0]      head_b;
    logic [3:0]       head_ctrl;
    logic [TAG_W-1:0] head_tag;

    // Flags come from the registered count, so a push is only visible to
    // the FSM one cycle later, and a full FIFO refuses pushes even when a
    // pop happens in the same cycle.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid && !full;

    assign {head_a, head_b, head_ctrl, head_tag} = mem_q[rd_ptr_q];

    // FIFO storage: write-only array, no reset needed since occupancy
    // is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_ctrl, bus.cmd_tag};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (lat_q == LAT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = empty ? IDLE : EXEC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM output / datapath logic
    always_comb begin
        pop         = 1'b0;
        lat_d       = lat_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        issue_tag_d = issue_tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_tag_d   = rsp_tag_q;

        case (state_q)
            IDLE: begin
                pop = !empty;
            end
            EXEC: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.alu_y;
                    rsp_zero_d  = (bus.alu_y == 32'd0);
                    rsp_tag_d   = issue_tag_q;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Chain straight into the next command without an
                    // IDLE bubble.
                    pop = !empty;
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase

        if (pop) begin
            alu_a_d     = head_a;
            alu_b_d     = head_b;
            alu_ctrl_d  = head_ctrl;
            issue_tag_d = head_tag;
            lat_d       = LAT_W'(ALU_LAT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lat_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            issue_tag_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lat_q       <= lat_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            issue_tag_q <= issue_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign busy          = (state_q != IDLE) || !empty;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with ALU_LAT=1 (dut1) and one
// with ALU_LAT=3 (dut3), each with its own ALU model and response scoreboard.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer_if #(.TAG_W(4)) i1 ();
    alu_cmd_sequencer_if #(.TAG_W(4)) i3 ();

    logic       busy1, busy3;
    logic [2:0] fc1, fc3;

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave), .busy(busy1), .fifo_count(fc1)
    );

    alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(3), .TAG_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(i3.slave), .busy(busy3), .fifo_count(fc3)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // ALU for dut1: purely combinational.
    assign i1.alu_y = alu_f(i1.alu_ctrl, i1.alu_a, i1.alu_b);

    // ALU for dut3: result only meaningful once inputs have been stable
    // for three cycles; sampling earlier yields DEADBEEF.
    logic [67:0] prev3 = '0;
    logic [1:0]  st3 = '0;
    always @(posedge clk) begin
        if ({i3.alu_a, i3.alu_b, i3.alu_ctrl} != prev3) st3 <= 2'd0;
        else if (st3 != 2'd3) st3 <= st3 + 2'd1;
        prev3 <= {i3.alu_a, i3.alu_b, i3.alu_ctrl};
    end
    assign i3.alu_y = (({i3.alu_a, i3.alu_b, i3.alu_ctrl} == prev3) && (st3 >= 2'd1))
                      ? alu_f(i3.alu_ctrl, i3.alu_a, i3.alu_b) : 32'hDEADBEEF;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  tag;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;
    int   rise1[$];
    int   rise3[$];
    logic pv1 = 1'b0, pv3 = 1'b0;
    int   last_push_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitors: compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && i1.rsp_valid && i1.rsp_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected actual data=%h tag=%h required no response", i1.rsp_data, i1.rsp_tag);
            end else begin
                e1 = q1.pop_front();
                if (i1.rsp_data !== e1.y || i1.rsp_zero !== (e1.y == 32'd0) || i1.rsp_tag !== e1.tag) begin
                    errors++;
                    $display("FAIL rsp1 actual data=%h zero=%b tag=%h required data=%h zero=%b tag=%h",
                             i1.rsp_data, i1.rsp_zero, i1.rsp_tag, e1.y, (e1.y == 32'd0), e1.tag);
                end
            end
        end
        if (i1.rsp_valid && !pv1) rise1.push_back(cyc);
        pv1 = i1.rsp_valid;
    end

    always @(negedge clk) begin
        if (rst_n && i3.rsp_valid && i3.rsp_ready) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL rsp3_unexpected actual data=%h tag=%h required no response", i3.rsp_data, i3.rsp_tag);
            end else begin
                e3 = q3.pop_front();
                if (i3.rsp_data !== e3.y || i3.rsp_zero !== (e3.y == 32'd0) || i3.rsp_tag !== e3.tag) begin
                    errors++;
                    $display("FAIL rsp3 actual data=%h zero=%b tag=%h required data=%h zero=%b tag=%h",
                             i3.rsp_data, i3.rsp_zero, i3.rsp_tag, e3.y, (e3.y == 32'd0), e3.tag);
                end
            end
        end
        if (i3.rsp_valid && !pv3) rise3.push_back(cyc);
        pv3 = i3.rsp_valid;
    end

    // Called just after a rising edge; returns just after the accepting edge
    // with cmd_valid still asserted.
    task automatic push(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl, input logic [3:0] tag, input logic [31:0] y);
        bit ok = 0;
        exp_t e;
        e.y = y;
        e.tag = tag;
        if (sel == 1) begin
            i1.cmd_a = a; i1.cmd_b = b; i1.cmd_ctrl = ctrl; i1.cmd_tag = tag; i1.cmd_valid = 1'b1;
        end else begin
            i3.cmd_a = a; i3.cmd_b = b; i3.cmd_ctrl = ctrl; i3.cmd_tag = tag; i3.cmd_valid = 1'b1;
        end
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = (sel == 1) ? i1.cmd_ready : i3.cmd_ready;
        end
        if (!ok) begin
            chk("push_accept_timeout", 32'd0, 32'd1);
            i1.cmd_valid = 1'b0;
            i3.cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        if (sel == 1) q1.push_back(e);
        else q3.push_back(e);
        #1;
        last_push_cyc = cyc;
    endtask

    task automatic wait_drain(input int sel, input string name);
        bit done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sel == 1) done = (q1.size() == 0) && !i1.rsp_valid && !busy1;
            else          done = (q3.size() == 0) && !i3.rsp_valid && !busy3;
        end
        chk(name, {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] a3 [5] = '{32'h0000_0001, 32'h0000_000F, 32'h0000_000A, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] b3 [5] = '{32'h0000_0002, 32'h0000_00F0, 32'h0000_0003, 32'hFFFF_0000, 32'h0000_0001};
    logic [3:0]  c3 [5] = '{4'b0010, 4'b0001, 4'b0110, 4'b1100, 4'b0111};
    logic [31:0] y3 [5] = '{32'h0000_0003, 32'h0000_00FF, 32'h0000_0007, 32'h0000_FFFF, 32'h0000_0001};

    logic [31:0] a_and [5] = '{32'hF0F0_F0F0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h8000_0001};
    logic [31:0] b_and [5] = '{32'hFF00_FF00, 32'h0000_FFFF, 32'h0000_0000, 32'h0F0F_0F0F, 32'hFFFF_FFFF};
    logic [31:0] y_and [5] = '{32'hF000_F000, 32'h0000_5678, 32'h0000_0000, 32'h0505_0505, 32'h8000_0001};

    logic [31:0] a6 [10] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    logic [31:0] b6 [10] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800, 32'h900};
    logic [31:0] y6 [10] = '{32'h000, 32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606, 32'h707, 32'h808, 32'h909};

    int p0;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i1.cmd_valid = 0; i1.cmd_a = 0; i1.cmd_b = 0; i1.cmd_ctrl = 0; i1.cmd_tag = 0; i1.rsp_ready = 1;
        i3.cmd_valid = 0; i3.cmd_a = 0; i3.cmd_b = 0; i3.cmd_ctrl = 0; i3.cmd_tag = 0; i3.rsp_ready = 1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", {31'd0, i1.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, i1.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_fifo_count", {29'd0, fc1}, 32'd0);
        chk("rst_alu_a", i1.alu_a, 32'd0);
        chk("rst_cmd_ready3", {31'd0, i3.cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single add, latency 2 edges
        push(1, 32'd5, 32'd7, 4'b0010, 4'd3, 32'd12);
        p0 = last_push_cyc;
        i1.cmd_valid = 1'b0;
        wait_drain(1, "t1_drained");
        chk("t1_rise_seen", rise1.size(), 32'd1);
        if (rise1.size() > 0) chk("t1_latency", rise1[0] - p0, 32'd2);

        // 2: sub to zero
        push(1, 32'd7, 32'd7, 4'b0110, 4'd5, 32'd0);
        i1.cmd_valid = 1'b0;
        wait_drain(1, "t2_drained");

        // 3: fill while the consumer stalls
        i1.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(1, a_and[i], b_and[i], 4'b0000, 4'(i), y_and[i]);
        i1.cmd_valid = 1'b0;
        chk("t3_fifo_full_count", {29'd0, fc1}, 32'd4);
        chk("t3_cmd_ready_low", {31'd0, i1.cmd_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy1}, 32'd1);
        chk("t3_rsp_valid_held", {31'd0, i1.rsp_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_count_stalled", {29'd0, fc1}, 32'd4);
        chk("t3_rsp_data_held", i1.rsp_data, 32'hF000_F000);
        chk("t3_rsp_tag_held", {28'd0, i1.rsp_tag}, 32'd0);
        i1.rsp_ready = 1'b1;
        wait_drain(1, "t3_drained");

        // 6: simultaneous push and pop at count 2, pointer wrap over 10 commands
        i1.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(1, a6[i], b6[i], 4'b0010, 4'(i), y6[i]);
        chk("t6_count_before", {29'd0, fc1}, 32'd2);
        chk("t6_rsp_valid_before", {31'd0, i1.rsp_valid}, 32'd1);
        i1.rsp_ready = 1'b1;
        push(1, a6[3], b6[3], 4'b0010, 4'd3, y6[3]);
        chk("t6_count_push_pop", {29'd0, fc1}, 32'd2);
        for (int i = 4; i < 10; i++) push(1, a6[i], b6[i], 4'b0010, 4'(i), y6[i]);
        i1.cmd_valid = 1'b0;
        wait_drain(1, "t6_drained");

        // 4: back-to-back with ALU_LAT=3
        rise3.delete();
        for (int i = 0; i < 5; i++) begin
            push(3, a3[i], b3[i], c3[i], 4'(i + 1), y3[i]);
            if (i == 0) p0 = last_push_cyc;
        end
        i3.cmd_valid = 1'b0;
        wait_drain(3, "t4_drained");
        chk("t4_rise_count", rise3.size(), 32'd5);
        if (rise3.size() == 5) begin
            chk("t4_first_latency", rise3[0] - p0, 32'd4);
            for (int k = 1; k < 5; k++) chk("t4_period", rise3[k] - rise3[k-1], 32'd4);
        end

        // 5: reset during EXEC with two queued
        for (int i = 0; i < 3; i++) push(3, a3[i], b3[i], c3[i], 4'(i + 8), y3[i]);
        i3.cmd_valid = 1'b0;
        chk("t5_count_before", {29'd0, fc3}, 32'd2);
        chk("t5_busy_before", {31'd0, busy3}, 32'd1);
        rst_n = 1'b0;
        #1;
        q3.delete();
        q1.delete();
        chk("t5_rsp_valid", {31'd0, i3.rsp_valid}, 32'd0);
        chk("t5_fifo_count", {29'd0, fc3}, 32'd0);
        chk("t5_busy", {31'd0, busy3}, 32'd0);
        chk("t5_cmd_ready", {31'd0, i3.cmd_ready}, 32'd1);
        chk("t5_alu_a", i3.alu_a, 32'd0);
        chk("t5_alu_b", i3.alu_b, 32'd0);
        chk("t5_alu_ctrl", {28'd0, i3.alu_ctrl}, 32'd0);
        chk("t5_rsp_data", i3.rsp_data, 32'd0);
        chk("t5_rsp_zero", {31'd0, i3.rsp_zero}, 32'd0);
        chk("t5_rsp_tag", {28'd0, i3.rsp_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("t5_post_count", {29'd0, fc3}, 32'd0);
        chk("t5_post_busy", {31'd0, busy3}, 32'd0);
        chk("t5_post_rsp_valid", {31'd0, i3.rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side driver for the team's 32-bit combinational ALU. It accepts operation requests (operands, 4-bit control, tag) over a valid/ready interface and buffers them in a small FIFO. It issues each request to the external ALU as registered A/B/CTRL, waits a programmable settle time, then captures the result and returns it with its tag over a valid/ready response interface. It sits between the datapath issue logic and the ALU instance, replacing ad-hoc direct wiring.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2.
ALU_LAT, 1, cycles ALU inputs are held stable before Y is sampled; minimum 1.
TAG_W, 4, width of the request tag returned with each result.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  request valid.
cmd_ready  output  1  request accept; equals !fifo_full.
cmd_a  input  32  operand A (shift amount in A[4:0] for shift ops).
cmd_b  input  32  operand B.
cmd_ctrl  input  4  ALU control, passed through unmodified.
cmd_tag  input  TAG_W  request tag.
alu_a  output  32  registered operand A to ALU.
alu_b  output  32  registered operand B to ALU.
alu_ctrl  output  4  registered control to ALU.
alu_y  input  32  ALU result.
rsp_valid  output  1  result valid.
rsp_ready  input  1  result accept.
rsp_data  output  32  captured result.
rsp_zero  output  1  1 when captured result == 0.
rsp_tag  output  TAG_W  tag of the captured request.
busy  output  1  1 when FSM is not IDLE or FIFO is non-empty.
fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low: FIFO empty, FSM=IDLE, and all outputs 0 except cmd_ready=1. Reset mid-operation discards in-flight and queued commands; rsp_valid drops immediately.
- Push occurs on cmd_valid&&cmd_ready at a rising edge. cmd_ready is !full only, so no push at full even if a pop occurs in the same cycle.
- The FIFO uses circular read/write pointers that wrap at DEPTH. fifo_count updates at the edge; simultaneous push and pop leaves it unchanged.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if the FIFO is non-empty, at the edge pop the head, load alu_a/alu_b/alu_ctrl and the tag, set cnt=ALU_LAT, and go to EXEC.
- EXEC: cnt decrements each edge. At the edge where cnt==1, capture alu_y into rsp_data, set rsp_zero=(alu_y==0), set rsp_tag, set rsp_valid=1, and go to RESP.
- RESP: rsp_data/zero/tag are held stable while rsp_valid && !rsp_ready. On the rsp_valid&&rsp_ready edge, clear rsp_valid. If the FIFO is non-empty at that edge, pop and load the next command directly (go to EXEC); otherwise go to IDLE.
- alu_a/alu_b/alu_ctrl hold their last issued values outside EXEC.
- Latency from push at edge N (FSM IDLE, FIFO empty) to rsp_valid high is 1+ALU_LAT edges. Steady-state throughput with rsp_ready=1 is one result per ALU_LAT+1 cycles.
- Responses are returned strictly in request order.
- A push to an empty FIFO in the same cycle the FSM checks IDLE is not seen until the next cycle (the registered empty flag governs).

Test Plan:
1. Reset release, ALU_LAT=1, push A=5 B=7 ctrl=4'b0010 (add) tag=3 -> rsp_valid high 2 edges after the push; rsp_data=12, rsp_zero=0, rsp_tag=3.
2. Push A=7 B=7 ctrl=4'b0110 (sub) -> rsp_data=0, rsp_zero=1.
3. Hold rsp_ready=0 and push DEPTH+1 commands -> cmd_ready=0 once fifo_count=4; one command stays in flight. Release rsp_ready -> results AND 0xF0F0F0F0&0xFF00FF00=0xF000F000 etc. arrive in tag order 0..4 with no loss.
4. Back-to-back with rsp_ready=1 and ALU_LAT=3 -> rsp_valid pulses every 4 cycles; alu_* stable for 3 cycles each.
5. Assert rst_n=0 during EXEC with 2 commands queued -> rsp_valid=0, fifo_count=0, busy=0, and all outputs 0 except cmd_ready=1 immediately; no stale response after release.
6. Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2; pointers wrap correctly across 10 commands.
